// File: rtl/duel_referee.sv
// Duel game-logic stage: per-side saber FSMs, per-frame hit tests and health.
// All outputs are registered for the display path.
module duel_referee #(
    parameter int MAX_HEALTH      = 5,
    parameter int ATTACK_FRAMES   = 30,
    parameter int COOLDOWN_FRAMES = 20
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        nf_in,
    input  logic        new_game_in,
    input  logic        player_attack_req_in,
    input  logic        opponent_attack_req_in,
    input  logic        player_block_in,
    input  logic        opponent_block_in,
    input  logic [11:0] player_saber_x_in,
    input  logic [11:0] opponent_saber_x_in,
    input  logic [10:0] player_saber_y_in,
    input  logic [10:0] opponent_saber_y_in,
    input  logic [11:0] player_box_x_in,
    input  logic [11:0] player_box_xmax_in,
    input  logic [10:0] player_box_y_in,
    input  logic [10:0] player_box_ymax_in,
    input  logic [11:0] opponent_box_x_in,
    input  logic [11:0] opponent_box_xmax_in,
    input  logic [10:0] opponent_box_y_in,
    input  logic [10:0] opponent_box_ymax_in,
    output logic [2:0]  player_health_out,
    output logic [2:0]  opponent_health_out,
    output logic [1:0]  player_saber_state_out,
    output logic [1:0]  opponent_saber_state_out,
    output logic [11:0] player_attack_x_out,
    output logic [11:0] opponent_attack_x_out,
    output logic [10:0] player_attack_y_out,
    output logic [10:0] opponent_attack_y_out,
    output logic        attack_valid_out,
    output logic        game_over_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ATTACK   = 2'd1,
        BLOCK    = 2'd2,
        COOLDOWN = 2'd3
    } saber_state_t;

    localparam int MAX_FRAMES =
        (ATTACK_FRAMES > COOLDOWN_FRAMES) ? ATTACK_FRAMES : COOLDOWN_FRAMES;
    localparam int NEED_W = $clog2(MAX_FRAMES + 1);
    localparam int CW     = (NEED_W > 6) ? NEED_W : 6;

    localparam logic [2:0]    HEALTH_INIT = 3'(MAX_HEALTH);
    localparam logic [CW-1:0] ATK_INIT    = CW'(ATTACK_FRAMES);
    localparam logic [CW-1:0] CD_INIT     = CW'(COOLDOWN_FRAMES);

    saber_state_t  p_state, o_state;
    saber_state_t  p_state_n, o_state_n;
    logic [CW-1:0] p_cnt, o_cnt;
    logic [CW-1:0] p_cnt_n, o_cnt_n;
    logic          p_latch, o_latch;

    logic p_inside, o_inside;
    logic p_hit, o_hit;
    logic p_dmg, o_dmg;
    logic frozen;

    assign player_saber_state_out   = p_state;
    assign opponent_saber_state_out = o_state;

    // Inclusive, unsigned containment of each tip in the other side's box.
    assign p_inside = (player_saber_x_in >= opponent_box_x_in)
                   && (player_saber_x_in <= opponent_box_xmax_in)
                   && (player_saber_y_in >= opponent_box_y_in)
                   && (player_saber_y_in <= opponent_box_ymax_in);

    assign o_inside = (opponent_saber_x_in >= player_box_x_in)
                   && (opponent_saber_x_in <= player_box_xmax_in)
                   && (opponent_saber_y_in >= player_box_y_in)
                   && (opponent_saber_y_in <= player_box_ymax_in);

    // Health at zero freezes play now, not only once game_over_out is up.
    assign frozen = game_over_out
                 || (player_health_out == 3'd0)
                 || (opponent_health_out == 3'd0);

    assign p_hit = nf_in && !frozen && (p_state == ATTACK) && p_inside;
    assign o_hit = nf_in && !frozen && (o_state == ATTACK) && o_inside;

    // Defender state is the pre-edge register, so trades always land.
    assign p_dmg = p_hit && (o_state != BLOCK);
    assign o_dmg = o_hit && (p_state != BLOCK);

    always_comb begin
        p_state_n = p_state;
        p_cnt_n   = p_cnt;
        p_latch   = 1'b0;
        unique case (p_state)
            IDLE: begin
                if (player_attack_req_in) begin
                    p_state_n = ATTACK;
                    p_cnt_n   = ATK_INIT;
                    p_latch   = 1'b1;
                end else if (player_block_in) begin
                    p_state_n = BLOCK;
                end
            end
            BLOCK: begin
                if (!player_block_in)
                    p_state_n = IDLE;
            end
            ATTACK: begin
                if (nf_in) begin
                    if (p_hit || p_cnt <= 1) begin
                        p_state_n = COOLDOWN;
                        p_cnt_n   = CD_INIT;
                    end else begin
                        p_cnt_n = p_cnt - 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                if (nf_in) begin
                    if (p_cnt <= 1) begin
                        p_state_n = IDLE;
                        p_cnt_n   = '0;
                    end else begin
                        p_cnt_n = p_cnt - 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        o_state_n = o_state;
        o_cnt_n   = o_cnt;
        o_latch   = 1'b0;
        unique case (o_state)
            IDLE: begin
                if (opponent_attack_req_in) begin
                    o_state_n = ATTACK;
                    o_cnt_n   = ATK_INIT;
                    o_latch   = 1'b1;
                end else if (opponent_block_in) begin
                    o_state_n = BLOCK;
                end
            end
            BLOCK: begin
                if (!opponent_block_in)
                    o_state_n = IDLE;
            end
            ATTACK: begin
                if (nf_in) begin
                    if (o_hit || o_cnt <= 1) begin
                        o_state_n = COOLDOWN;
                        o_cnt_n   = CD_INIT;
                    end else begin
                        o_cnt_n = o_cnt - 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                if (nf_in) begin
                    if (o_cnt <= 1) begin
                        o_state_n = IDLE;
                        o_cnt_n   = '0;
                    end else begin
                        o_cnt_n = o_cnt - 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            p_state               <= IDLE;
            o_state               <= IDLE;
            p_cnt                 <= '0;
            o_cnt                 <= '0;
            player_health_out     <= HEALTH_INIT;
            opponent_health_out   <= HEALTH_INIT;
            player_attack_x_out   <= '0;
            player_attack_y_out   <= '0;
            opponent_attack_x_out <= '0;
            opponent_attack_y_out <= '0;
            attack_valid_out      <= 1'b0;
            game_over_out         <= 1'b0;
        end else if (new_game_in) begin
            p_state             <= IDLE;
            o_state             <= IDLE;
            p_cnt               <= '0;
            o_cnt               <= '0;
            player_health_out   <= HEALTH_INIT;
            opponent_health_out <= HEALTH_INIT;
            attack_valid_out    <= 1'b0;
            game_over_out       <= 1'b0;
        end else if (frozen) begin
            p_state          <= IDLE;
            o_state          <= IDLE;
            p_cnt            <= '0;
            o_cnt            <= '0;
            attack_valid_out <= 1'b0;
            game_over_out    <= 1'b1;
        end else begin
            p_state          <= p_state_n;
            o_state          <= o_state_n;
            p_cnt            <= p_cnt_n;
            o_cnt            <= o_cnt_n;
            attack_valid_out <= p_dmg || o_dmg;
            game_over_out    <= 1'b0;
            if (p_latch) begin
                player_attack_x_out <= player_saber_x_in;
                player_attack_y_out <= player_saber_y_in;
            end
            if (o_latch) begin
                opponent_attack_x_out <= opponent_saber_x_in;
                opponent_attack_y_out <= opponent_saber_y_in;
            end
            if (p_dmg && opponent_health_out != 3'd0)
                opponent_health_out <= opponent_health_out - 3'd1;
            if (o_dmg && player_health_out != 3'd0)
                player_health_out <= player_health_out - 3'd1;
        end
    end

endmodule

// File: tb/tb_duel_referee.sv
// Directed bench for duel_referee: attacks, blocks, timeouts, trades,
// game over, new game and asynchronous reset.
module tb_duel_referee;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        nf_in = 1'b0;
    logic        new_game_in = 1'b0;
    logic        player_attack_req_in = 1'b0;
    logic        opponent_attack_req_in = 1'b0;
    logic        player_block_in = 1'b0;
    logic        opponent_block_in = 1'b0;
    logic [11:0] player_saber_x_in = '0;
    logic [11:0] opponent_saber_x_in = '0;
    logic [10:0] player_saber_y_in = '0;
    logic [10:0] opponent_saber_y_in = '0;
    logic [11:0] player_box_x_in = 12'd500;
    logic [11:0] player_box_xmax_in = 12'd600;
    logic [10:0] player_box_y_in = 11'd300;
    logic [10:0] player_box_ymax_in = 11'd400;
    logic [11:0] opponent_box_x_in = 12'd250;
    logic [11:0] opponent_box_xmax_in = 12'd350;
    logic [10:0] opponent_box_y_in = 11'd150;
    logic [10:0] opponent_box_ymax_in = 11'd250;
    logic [2:0]  player_health_out;
    logic [2:0]  opponent_health_out;
    logic [1:0]  player_saber_state_out;
    logic [1:0]  opponent_saber_state_out;
    logic [11:0] player_attack_x_out;
    logic [11:0] opponent_attack_x_out;
    logic [10:0] player_attack_y_out;
    logic [10:0] opponent_attack_y_out;
    logic        attack_valid_out;
    logic        game_over_out;

    int checks = 0;
    int failures = 0;

    duel_referee dut (
        .clk_in                   (clk_in),
        .rst_in                   (rst_in),
        .nf_in                    (nf_in),
        .new_game_in              (new_game_in),
        .player_attack_req_in     (player_attack_req_in),
        .opponent_attack_req_in   (opponent_attack_req_in),
        .player_block_in          (player_block_in),
        .opponent_block_in        (opponent_block_in),
        .player_saber_x_in        (player_saber_x_in),
        .opponent_saber_x_in      (opponent_saber_x_in),
        .player_saber_y_in        (player_saber_y_in),
        .opponent_saber_y_in      (opponent_saber_y_in),
        .player_box_x_in          (player_box_x_in),
        .player_box_xmax_in       (player_box_xmax_in),
        .player_box_y_in          (player_box_y_in),
        .player_box_ymax_in       (player_box_ymax_in),
        .opponent_box_x_in        (opponent_box_x_in),
        .opponent_box_xmax_in     (opponent_box_xmax_in),
        .opponent_box_y_in        (opponent_box_y_in),
        .opponent_box_ymax_in     (opponent_box_ymax_in),
        .player_health_out        (player_health_out),
        .opponent_health_out      (opponent_health_out),
        .player_saber_state_out   (player_saber_state_out),
        .opponent_saber_state_out (opponent_saber_state_out),
        .player_attack_x_out      (player_attack_x_out),
        .opponent_attack_x_out    (opponent_attack_x_out),
        .player_attack_y_out      (player_attack_y_out),
        .opponent_attack_y_out    (opponent_attack_y_out),
        .attack_valid_out         (attack_valid_out),
        .game_over_out            (game_over_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic nfs(input int n);
        repeat (n) begin
            nf_in = 1'b1;
            tick();
            nf_in = 1'b0;
            tick();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1;
        tick();
        tick();
        chk("rst_p_health", player_health_out, 5);
        chk("rst_o_health", opponent_health_out, 5);
        chk("rst_p_state", player_saber_state_out, 0);
        chk("rst_o_state", opponent_saber_state_out, 0);
        chk("rst_p_ax", player_attack_x_out, 0);
        chk("rst_valid", attack_valid_out, 0);
        chk("rst_go", game_over_out, 0);
        rst_in = 1'b0;
        tick();

        // attack request latches origin
        player_saber_x_in = 12'd100;
        player_saber_y_in = 11'd50;
        player_attack_req_in = 1'b1;
        tick();
        player_attack_req_in = 1'b0;
        chk("atk_state", player_saber_state_out, 1);
        chk("atk_ax", player_attack_x_out, 100);
        chk("atk_ay", player_attack_y_out, 50);
        chk("atk_p_health", player_health_out, 5);
        chk("atk_o_health", opponent_health_out, 5);

        // hit on idle opponent
        player_saber_x_in = 12'd300;
        player_saber_y_in = 11'd200;
        nf_in = 1'b1;
        tick();
        nf_in = 1'b0;
        chk("hit_o_health", opponent_health_out, 4);
        chk("hit_p_state", player_saber_state_out, 3);
        chk("hit_valid", attack_valid_out, 1);
        tick();
        chk("hit_valid_drop", attack_valid_out, 0);
        chk("hit_ax_hold", player_attack_x_out, 100);
        nfs(19);
        chk("cd19_state", player_saber_state_out, 3);
        nfs(1);
        chk("cd20_state", player_saber_state_out, 0);

        // hit on blocking opponent
        opponent_block_in = 1'b1;
        tick();
        chk("blk_o_state", opponent_saber_state_out, 2);
        opponent_attack_req_in = 1'b1;
        player_attack_req_in = 1'b1;
        tick();
        opponent_attack_req_in = 1'b0;
        player_attack_req_in = 1'b0;
        chk("blk_ignores_req", opponent_saber_state_out, 2);
        chk("blk_p_atk", player_saber_state_out, 1);
        chk("blk_ax", player_attack_x_out, 300);
        nf_in = 1'b1;
        tick();
        nf_in = 1'b0;
        chk("blk_o_health", opponent_health_out, 4);
        chk("blk_valid", attack_valid_out, 0);
        chk("blk_p_state", player_saber_state_out, 3);
        opponent_block_in = 1'b0;
        tick();
        chk("unblk_o_state", opponent_saber_state_out, 0);
        nfs(20);
        chk("blk_cd_done", player_saber_state_out, 0);

        // timeout with no hit
        player_saber_x_in = 12'd100;
        player_saber_y_in = 11'd50;
        player_attack_req_in = 1'b1;
        tick();
        player_attack_req_in = 1'b0;
        nfs(29);
        chk("to29_state", player_saber_state_out, 1);
        nfs(1);
        chk("to30_state", player_saber_state_out, 3);
        chk("to_o_health", opponent_health_out, 4);
        nfs(20);
        chk("to_cd_done", player_saber_state_out, 0);

        // attack beats block; inclusive box corner
        player_saber_x_in = 12'd351;
        player_saber_y_in = 11'd250;
        player_attack_req_in = 1'b1;
        player_block_in = 1'b1;
        tick();
        player_attack_req_in = 1'b0;
        player_block_in = 1'b0;
        chk("atk_beats_blk", player_saber_state_out, 1);
        nf_in = 1'b1;
        tick();
        nf_in = 1'b0;
        chk("edge_miss_health", opponent_health_out, 4);
        chk("edge_miss_state", player_saber_state_out, 1);
        player_saber_x_in = 12'd350;
        nf_in = 1'b1;
        tick();
        nf_in = 1'b0;
        chk("edge_hit_health", opponent_health_out, 3);
        chk("edge_hit_valid", attack_valid_out, 1);
        nfs(20);

        // trades down to zero
        new_game_in = 1'b1;
        tick();
        new_game_in = 1'b0;
        chk("ng1_p_health", player_health_out, 5);
        chk("ng1_o_health", opponent_health_out, 5);
        player_saber_x_in = 12'd300;
        player_saber_y_in = 11'd200;
        opponent_saber_x_in = 12'd550;
        opponent_saber_y_in = 11'd350;
        for (int k = 1; k <= 5; k++) begin
            player_attack_req_in = 1'b1;
            opponent_attack_req_in = 1'b1;
            tick();
            player_attack_req_in = 1'b0;
            opponent_attack_req_in = 1'b0;
            nf_in = 1'b1;
            tick();
            nf_in = 1'b0;
            chk("trade_p_health", player_health_out, 32'(5 - k));
            chk("trade_o_health", opponent_health_out, 32'(5 - k));
            chk("trade_valid", attack_valid_out, 1);
            if (k < 5) nfs(20);
        end
        chk("go_not_yet", game_over_out, 0);
        tick();
        chk("go_set", game_over_out, 1);
        chk("go_p_idle", player_saber_state_out, 0);
        chk("go_o_idle", opponent_saber_state_out, 0);
        chk("go_valid", attack_valid_out, 0);
        player_attack_req_in = 1'b1;
        opponent_attack_req_in = 1'b1;
        tick();
        player_attack_req_in = 1'b0;
        opponent_attack_req_in = 1'b0;
        nf_in = 1'b1;
        tick();
        nf_in = 1'b0;
        chk("go_req_ign", player_saber_state_out, 0);
        chk("go_p_hold", player_health_out, 0);
        chk("go_o_hold", opponent_health_out, 0);
        chk("go_still", game_over_out, 1);

        // new game overrides a same-cycle request
        new_game_in = 1'b1;
        player_attack_req_in = 1'b1;
        tick();
        new_game_in = 1'b0;
        player_attack_req_in = 1'b0;
        chk("ng_p_health", player_health_out, 5);
        chk("ng_o_health", opponent_health_out, 5);
        chk("ng_p_state", player_saber_state_out, 0);
        chk("ng_go", game_over_out, 0);
        chk("ng_ax_hold", player_attack_x_out, 300);
        chk("ng_o_ay_hold", opponent_attack_y_out, 350);

        // asynchronous reset mid-attack
        player_attack_req_in = 1'b1;
        tick();
        player_attack_req_in = 1'b0;
        nf_in = 1'b1;
        tick();
        nf_in = 1'b0;
        chk("pre_rst_health", opponent_health_out, 4);
        nfs(20);
        player_attack_req_in = 1'b1;
        tick();
        player_attack_req_in = 1'b0;
        chk("pre_rst_state", player_saber_state_out, 1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_p_state", player_saber_state_out, 0);
        chk("arst_o_health", opponent_health_out, 5);
        chk("arst_ax", player_attack_x_out, 0);
        chk("arst_o_ay", opponent_attack_y_out, 0);
        tick();
        rst_in = 1'b0;
        nf_in = 1'b1;
        tick();
        nf_in = 1'b0;
        chk("post_rst_state", player_saber_state_out, 0);
        chk("post_rst_health", opponent_health_out, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
